// File: rtl/button_debounce_multi.sv
// button_debounce_multi: N independent push-button channels with synchroniser, debounce,
// press/release pulses, long-press and auto-repeat events. Rev 1.0
`default_nettype none

module button_debounce_multi #(
   parameter int NUM_BTN      = 4,
   parameter int DEBOUNCE_CYC = 500_000,
   parameter int LONG_CYC     = 100_000_000,
   parameter int REPEAT_CYC   = 25_000_000,
   parameter bit ACTIVE_HIGH  = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [NUM_BTN-1:0] i_button,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic [NUM_BTN-1:0] o_release,
   output logic [NUM_BTN-1:0] o_long,
   output logic [NUM_BTN-1:0] o_repeat
);

   localparam int DB_W       = $clog2(DEBOUNCE_CYC + 1);
   localparam int HOLD_W     = $clog2(LONG_CYC + 1);
   localparam int REP_W      = (REPEAT_CYC > 0) ? $clog2(REPEAT_CYC + 1) : 1;
   localparam int DB_LAST_I  = DEBOUNCE_CYC - 1;
   localparam int HOLD_LAST_I = LONG_CYC - 1;
   localparam int REP_LAST_I = (REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_LAST_I[DB_W-1:0];
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LAST_I[HOLD_W-1:0];
   localparam logic [REP_W-1:0]  REP_LAST  = REP_LAST_I[REP_W-1:0];
   localparam logic              IDLE_PIN  = ACTIVE_HIGH ? 1'b0 : 1'b1;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PRESS_WAIT = 3'd1,
      S_HELD       = 3'd2,
      S_LONG_HELD  = 3'd3,
      S_REL_WAIT   = 3'd4
   } state_t;

   logic [NUM_BTN-1:0] sync1;
   logic [NUM_BTN-1:0] sync2;
   logic [NUM_BTN-1:0] raw;

   // Reset parks the synchroniser at the released level so a button held through
   // reset is seen as a fresh press once reset lifts.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         sync1 <= {NUM_BTN{IDLE_PIN}};
         sync2 <= {NUM_BTN{IDLE_PIN}};
      end else begin
         sync1 <= i_button;
         sync2 <= sync1;
      end
   end

   assign raw = ACTIVE_HIGH ? sync2 : ~sync2;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      state_t            state,     state_nx;
      logic [DB_W-1:0]   db_cnt,    db_cnt_nx;
      logic [HOLD_W-1:0] hold_cnt,  hold_cnt_nx;
      logic [REP_W-1:0]  rep_cnt,   rep_cnt_nx;
      logic              long_flag, long_flag_nx;
      logic              level_q,   level_nx;
      logic              press_q,   press_nx;
      logic              rel_q,     rel_nx;
      logic              lng_q,     lng_nx;
      logic              rep_q,     rep_nx;

      always_ff @(posedge i_clk) begin
         if (!i_reset_n) begin
            state     <= S_IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            long_flag <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            lng_q     <= 1'b0;
            rep_q     <= 1'b0;
         end else begin
            state     <= state_nx;
            db_cnt    <= db_cnt_nx;
            hold_cnt  <= hold_cnt_nx;
            rep_cnt   <= rep_cnt_nx;
            long_flag <= long_flag_nx;
            level_q   <= level_nx;
            press_q   <= press_nx;
            rel_q     <= rel_nx;
            lng_q     <= lng_nx;
            rep_q     <= rep_nx;
         end
      end

      always_comb begin
         state_nx     = state;
         db_cnt_nx    = db_cnt;
         hold_cnt_nx  = hold_cnt;
         rep_cnt_nx   = rep_cnt;
         long_flag_nx = long_flag;
         level_nx     = level_q;
         press_nx     = 1'b0;
         rel_nx       = 1'b0;
         lng_nx       = 1'b0;
         rep_nx       = 1'b0;
         case (state)
            S_IDLE: begin
               if (raw[i]) begin
                  state_nx  = S_PRESS_WAIT;
                  db_cnt_nx = '0;
               end
            end
            S_PRESS_WAIT: begin
               if (!raw[i]) begin
                  state_nx = S_IDLE;
               end else if (db_cnt == DB_LAST) begin
                  state_nx    = S_HELD;
                  press_nx    = 1'b1;
                  level_nx    = 1'b1;
                  hold_cnt_nx = '0;
               end else begin
                  db_cnt_nx = db_cnt + 1'b1;
               end
            end
            S_HELD: begin
               if (!raw[i]) begin
                  state_nx  = S_REL_WAIT;
                  db_cnt_nx = '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state_nx     = S_LONG_HELD;
                  lng_nx       = 1'b1;
                  long_flag_nx = 1'b1;
                  rep_cnt_nx   = '0;
               end else begin
                  hold_cnt_nx = hold_cnt + 1'b1;
               end
            end
            S_LONG_HELD: begin
               if (!raw[i]) begin
                  state_nx  = S_REL_WAIT;
                  db_cnt_nx = '0;
               end else if (REPEAT_CYC != 0) begin
                  if (rep_cnt == REP_LAST) begin
                     rep_nx     = 1'b1;
                     rep_cnt_nx = '0;
                  end else begin
                     rep_cnt_nx = rep_cnt + 1'b1;
                  end
               end
            end
            S_REL_WAIT: begin
               // A bounce back to pushed resumes the hold with counters frozen.
               if (raw[i]) begin
                  state_nx = long_flag ? S_LONG_HELD : S_HELD;
               end else if (db_cnt == DB_LAST) begin
                  state_nx     = S_IDLE;
                  rel_nx       = 1'b1;
                  level_nx     = 1'b0;
                  long_flag_nx = 1'b0;
               end else begin
                  db_cnt_nx = db_cnt + 1'b1;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end

      assign o_level[i]   = level_q;
      assign o_press[i]   = press_q;
      assign o_release[i] = rel_q;
      assign o_long[i]    = lng_q;
      assign o_repeat[i]  = rep_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench for button_debounce_multi: two instances (active-high and active-low,
// different timing) checked every cycle against a run-length reference model.
`default_nettype none

module tb_button_debounce_multi;

   localparam int N = 2;

   logic       clk;
   logic       rst_n;
   logic [1:0] btn;
   logic [1:0] btn_n;

   logic [1:0] lvl_a, prs_a, rls_a, lng_a, rpt_a;
   logic [1:0] lvl_b, prs_b, rls_b, lng_b, rpt_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [9:0] q_a[$];
   logic [9:0] q_b[$];

   assign btn_n = ~btn;

   button_debounce_multi #(
      .NUM_BTN(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(5), .ACTIVE_HIGH(1'b1)
   ) dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_button(btn),
      .o_level(lvl_a), .o_press(prs_a), .o_release(rls_a), .o_long(lng_a), .o_repeat(rpt_a)
   );

   button_debounce_multi #(
      .NUM_BTN(2), .DEBOUNCE_CYC(2), .LONG_CYC(6), .REPEAT_CYC(0), .ACTIVE_HIGH(1'b0)
   ) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_button(btn_n),
      .o_level(lvl_b), .o_press(prs_b), .o_release(rls_b), .o_long(lng_b), .o_repeat(rpt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model, expressed in pushed-level terms: a press is accepted after
   // DEBOUNCE+1 consecutive pushed samples at the FSM input, a release after
   // DEBOUNCE+1 consecutive released samples. Hold time accrues only on samples
   // where both this and the previous sample were pushed.
   function automatic int par_d(input int k); return (k == 0) ? 4 : 2; endfunction
   function automatic int par_l(input int k); return (k == 0) ? 20 : 6; endfunction
   function automatic int par_r(input int k); return (k == 0) ? 5 : 0; endfunction

   bit m_s1  [2][2];
   bit m_s2  [2][2];
   bit m_lvl [2][2];
   bit m_prv [2][2];
   int m_run [2][2];
   int m_hold[2][2];

   task automatic model_step(input int k, output logic [9:0] e);
      logic [1:0] lv, pr, rl, lg, rp;
      bit raw;
      lv = '0; pr = '0; rl = '0; lg = '0; rp = '0;
      for (int c = 0; c < N; c++) begin
         if (!rst_n) begin
            m_s1[k][c] = 0; m_s2[k][c] = 0; m_lvl[k][c] = 0; m_prv[k][c] = 0;
            m_run[k][c] = 0; m_hold[k][c] = 0;
         end else begin
            raw = m_s2[k][c];
            m_s2[k][c] = m_s1[k][c];
            m_s1[k][c] = btn[c];
            if (!m_lvl[k][c]) begin
               m_run[k][c] = raw ? m_run[k][c] + 1 : 0;
               if (m_run[k][c] == par_d(k) + 1) begin
                  pr[c] = 1'b1;
                  m_lvl[k][c] = 1; m_run[k][c] = 0; m_hold[k][c] = 0; m_prv[k][c] = 1;
               end
            end else begin
               if (raw) begin
                  m_run[k][c] = 0;
                  if (m_prv[k][c]) begin
                     m_hold[k][c]++;
                     if (m_hold[k][c] == par_l(k))
                        lg[c] = 1'b1;
                     else if (m_hold[k][c] > par_l(k) && par_r(k) > 0 &&
                              ((m_hold[k][c] - par_l(k)) % par_r(k)) == 0)
                        rp[c] = 1'b1;
                  end
               end else begin
                  m_run[k][c]++;
                  if (m_run[k][c] == par_d(k) + 1) begin
                     rl[c] = 1'b1;
                     m_lvl[k][c] = 0; m_run[k][c] = 0;
                  end
               end
               m_prv[k][c] = raw;
            end
         end
         lv[c] = m_lvl[k][c];
      end
      e = {lv, pr, rl, lg, rp};
   endtask

   initial begin
      logic [9:0] e;
      forever begin
         @(posedge clk);
         model_step(0, e); q_a.push_back(e);
         model_step(1, e); q_b.push_back(e);
      end
   end

   // Monitor: DUT outputs are registered and valid every cycle, so one expected
   // entry is consumed per instance on each falling edge.
   initial begin
      logic [9:0] exp_v, got_v;
      forever begin
         @(negedge clk);
         cyc++;
         if (q_a.size() == 0 || q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty cycle %0d actual empty required entry", cyc);
         end else begin
            exp_v = q_a.pop_front();
            got_v = {lvl_a, prs_a, rls_a, lng_a, rpt_a};
            checks++;
            if (got_v !== exp_v) begin
               errors++;
               $display("FAIL dut_a cycle %0d actual lvl/prs/rls/lng/rpt=%b required %b",
                        cyc, got_v, exp_v);
            end
            exp_v = q_b.pop_front();
            got_v = {lvl_b, prs_b, rls_b, lng_b, rpt_b};
            checks++;
            if (got_v !== exp_v) begin
               errors++;
               $display("FAIL dut_b cycle %0d actual lvl/prs/rls/lng/rpt=%b required %b",
                        cyc, got_v, exp_v);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = 2'b01;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(15);
      btn = 2'b00;
      wait_cyc(15);

      repeat (5) begin
         btn[0] = 1'b1; wait_cyc(3);
         btn[0] = 1'b0; wait_cyc(2);
      end
      wait_cyc(10);

      btn = 2'b01; wait_cyc(10);
      btn = 2'b00; wait_cyc(12);

      btn = 2'b01; wait_cyc(60);
      btn = 2'b00; wait_cyc(12);

      btn = 2'b01; wait_cyc(35);
      btn = 2'b00; wait_cyc(2);
      btn = 2'b01; wait_cyc(20);
      btn = 2'b00; wait_cyc(12);

      btn = 2'b11; wait_cyc(12);
      btn = 2'b00; wait_cyc(12);

      btn = 2'b11; wait_cyc(30);
      rst_n = 1'b0; wait_cyc(2);
      btn = 2'b00; rst_n = 1'b1; wait_cyc(12);

      repeat (150) begin
         btn = 2'($urandom);
         if ($urandom_range(0, 24) == 0) begin
            rst_n = 1'b0; wait_cyc(int'($urandom_range(1, 3)));
            rst_n = 1'b1;
         end
         wait_cyc(int'($urandom_range(1, 35)));
      end

      btn = 2'b00;
      wait_cyc(40);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
